dii_event_chain_arbiter: RTL and testbench
==========================================

// Module: dii_event_chain_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter merging NUM_PORTS DI flit streams into one
//  stream feeding the host-side header-discard/event-combining stage.
//  Grant is held for a whole packet and across an entire event chain: packets
//  whose FLAGS word has data[13:10]==4'b0001 ("more events follow"), up to and
//  including the closing packet. This keeps combined event packets uninterleaved.
// PARAMETERS
//  NUM_PORTS  4  number of requesting input streams (>=1)
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    synchronous reset, active-high
//  in_flit    in   dii_flit[NUM_PORTS]  requester flits {valid,last,data[15:0]}
//  in_ready   out  NUM_PORTS            per-requester ready
//  out_flit   out  dii_flit             merged output stream
//  out_ready  in   1                    downstream ready
//  grant      out  NUM_PORTS            one-hot current owner, 0 when IDLE
//  busy       out  1                    1 while state==ACTIVE
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, rr_ptr=0, flit_cnt=0, more_ev=0;
//   out_flit.valid=0, in_ready=0, busy=0.
//  State IDLE: out_flit all-zero, in_ready all 0.
//   If any in_flit[i].valid: pick the first valid index scanning rr_ptr,
//   rr_ptr+1, ... (mod NUM_PORTS). Register grant, then ACTIVE with flit_cnt=0.
//   Arbitration costs exactly 1 bubble cycle; no flit transfers in IDLE.
//  State ACTIVE (owner g):
//   out_flit = in_flit[g] (combinational pass-through, 0 latency).
//   in_ready[g] = out_ready; all other in_ready = 0.
//   Transfer := in_flit[g].valid & out_ready.
//  flit_cnt: 0=DEST, 1=SRC, 2=FLAGS, 3=PAYLOAD.
//   Increments on each transfer and saturates at 3.
//  On the FLAGS transfer (flit_cnt==2): more_ev <= (data[13:10]==4'b0001).
//  On a transfer with last=1:
//   - flit_cnt<=2 (malformed short packet): chain ends unconditionally.
//   - else if more_ev: stay ACTIVE on g, flit_cnt<=0, more_ev<=0.
//   - else: state<=IDLE, grant<=0, rr_ptr<=(g+1) mod NUM_PORTS.
//  Back-to-back: within a chain, 1 flit/cycle sustained.
//   Packet boundaries inside a chain cost no bubble.
//  No timeout: a source stalling mid-chain blocks the others. Sources must
//   complete chains; this is documented, not enforced.
//  Non-owner valids are ignored and held off; no flit is ever dropped or
//   duplicated.
//  rst mid-packet: immediate return to reset values on the next edge. The
//   partial packet is not replayed; downstream is resynced by its own reset.
//  NUM_PORTS==1: rr_ptr stays 0; behaviour otherwise identical.
//   Index width is max(1,$clog2(NUM_PORTS)).
//  out_flit.data and out_flit.last are 0 whenever out_flit.valid is 0.
// TESTING
//  1 Ports 0,2 valid together, 4-flit packets, flags=0 -> port0 packet then
//    port2, 1 idle cycle between; rr_ptr ends at 3.
//  2 Port1 sends 3 packets with flags 0x0400,0x0400,0x0000 while port0 is
//    valid -> all 3 of port1 go contiguous; port0 is granted only after the
//    third last.
//  3 out_ready toggles 1/0 every cycle during a payload -> in_ready[g]
//    mirrors it; no duplicated or lost flits; order matches the scoreboard.
//  4 Port3 sends 2-flit packet (last on SRC) with prior more_ev=1 -> chain
//    ends, state IDLE, rr_ptr=0.
//  5 rst asserted during port2 FLAGS flit -> next cycle grant=0,
//    out_flit.valid=0, in_ready=0; the next packet from port0 is arbitrated
//    normally.
//  6 All 4 ports continuously valid, 100 packets -> each port receives 25
//    grants, max wait 3 packets.

Source files
------------

// File: rtl/dii_event_chain_arbiter_if.sv
// rtl/dii_event_chain_arbiter_if.sv - flit stream bundle between DI sources, arbiter and host stage
interface dii_event_chain_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    // Flit layout: [17] valid, [16] last, [15:0] data
    logic [NUM_PORTS-1:0][17:0] in_flit;
    logic [NUM_PORTS-1:0]       in_ready;
    logic [17:0]                out_flit;
    logic                       out_ready;

    // Environment side: drives the requesters and the downstream ready
    modport master (
        output in_flit,
        input  in_ready,
        input  out_flit,
        output out_ready
    );

    // Arbiter side
    modport slave (
        input  in_flit,
        output in_ready,
        output out_flit,
        input  out_ready
    );
endinterface

// File: rtl/dii_event_chain_arbiter.sv
// rtl/dii_event_chain_arbiter.sv - packet-atomic, event-chain-atomic round-robin flit arbiter
module dii_event_chain_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    dii_event_chain_arbiter_if.slave bus,
    output logic [NUM_PORTS-1:0]     grant,
    output logic                     busy
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int VB = 17;
    localparam int LB = 16;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]           flit_cnt_q, flit_cnt_d;
    logic                 more_ev_q, more_ev_d;

    logic                 pick_found;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        scan_idx;
    logic [17:0]          own_flit;
    logic                 xfer;
    logic                 chain_end;
    logic [IW-1:0]        owner_next;

    // Round-robin scan: first valid requester starting at rr_ptr and wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!pick_found && bus.in_flit[scan_idx][VB]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Port index following the owner, wrapping at NUM_PORTS (stays 0 for one port)
    always_comb begin
        owner_next = '0;
        if (owner_q != IW'(NUM_PORTS - 1)) begin
            owner_next = owner_q + 1'b1;
        end
    end

    // Next-state, pass-through mux and per-requester ready
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        flit_cnt_d   = flit_cnt_q;
        more_ev_d    = more_ev_q;
        bus.out_flit = '0;
        bus.in_ready = '0;
        xfer         = 1'b0;
        chain_end    = 1'b0;
        own_flit     = bus.in_flit[owner_q];

        case (state_q)
            IDLE: begin
                // Arbitration takes one bubble cycle; nothing moves here
                if (pick_found) begin
                    state_d    = ACTIVE;
                    owner_d    = pick_idx;
                    grant_d    = NUM_PORTS'(1) << pick_idx;
                    flit_cnt_d = 2'd0;
                    more_ev_d  = 1'b0;
                end
            end
            ACTIVE: begin
                // Zero-latency pass-through; data/last forced to 0 when not valid
                if (own_flit[VB]) begin
                    bus.out_flit = own_flit;
                end
                bus.in_ready[owner_q] = bus.out_ready;
                xfer = own_flit[VB] & bus.out_ready;
                if (xfer) begin
                    if (flit_cnt_q != 2'd3) begin
                        flit_cnt_d = flit_cnt_q + 2'd1;
                    end
                    if (flit_cnt_q == 2'd2) begin
                        more_ev_d = (own_flit[13:10] == 4'b0001);
                    end
                    if (own_flit[LB]) begin
                        // A short packet always closes the chain, whatever more_ev says
                        chain_end = (flit_cnt_q != 2'd3) || !more_ev_q;
                        flit_cnt_d = 2'd0;
                        more_ev_d  = 1'b0;
                        if (chain_end) begin
                            state_d  = IDLE;
                            grant_d  = '0;
                            rr_ptr_d = owner_next;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            flit_cnt_q <= 2'd0;
            more_ev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            flit_cnt_q <= flit_cnt_d;
            more_ev_q  <= more_ev_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ACTIVE);

endmodule

// File: tb/tb_dii_event_chain_arbiter.sv
// tb/tb_dii_event_chain_arbiter.sv - directed self-checking bench for dii_event_chain_arbiter
module tb_dii_event_chain_arbiter;
    localparam int NP    = 4;
    localparam int VB    = 17;
    localparam int LB    = 16;
    localparam int DEPTH = 160;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] grant;
    logic          busy;

    dii_event_chain_arbiter_if #(.NUM_PORTS(NP)) bus ();

    dii_event_chain_arbiter #(.NUM_PORTS(NP)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .grant(grant),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic [16:0]   mem [NP][DEPTH];
    int            head [NP];
    int            tail [NP];
    int            exp_rd [NP];
    int            ser;
    int            n_chk;
    int            n_pass;
    logic [15:0]   log_data [1024];
    logic          log_last [1024];
    int            log_port [1024];
    int            log_cyc [1024];
    int            n_log;
    int            log_base;
    int            gnt_seq [256];
    int            n_gnt;
    int            gnt_base;
    logic [NP-1:0] prev_grant;
    int            cyc;
    int            viol;
    bit            rdy_toggle;
    int            exp_q [$];
    int            c0;

    task automatic chk(string tag, int obs, int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            bus.in_flit[p] = (head[p] < tail[p]) ? {1'b1, mem[p][head[p]]} : 18'd0;
        end
    endtask

    // Non-FLAGS flits carry 0001 in [13:10] so only the FLAGS word may start a chain
    task automatic push_pkt(int p, int nfl, logic [13:0] flags);
        logic [15:0] d;
        for (int i = 0; i < nfl; i++) begin
            if (i == 2) begin
                d = {p[1:0], flags};
            end else begin
                d = {p[1:0], 4'b0001, 2'b00, ser[7:0]};
                ser++;
            end
            mem[p][tail[p]] = {(i == nfl - 1), d};
            tail[p]++;
        end
        drive();
    endtask

    task automatic expect_port(int p, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(p);
    endtask

    task automatic step();
        int   g;
        logic pop [NP];
        @(negedge clk);
        g = -1;
        for (int p = 0; p < NP; p++) if (grant[p]) g = p;
        if (grant != '0 && !$onehot(grant)) viol++;
        if (busy != (grant != '0)) viol++;
        if (g < 0) begin
            if (bus.out_flit != 18'd0 || bus.in_ready != '0) viol++;
        end else begin
            if (bus.in_ready != (NP'(bus.out_ready) << g)) viol++;
            if (bus.out_flit != (bus.in_flit[g][VB] ? bus.in_flit[g] : 18'd0)) viol++;
        end
        if (bus.out_flit[VB] && bus.out_ready && n_log < 1024) begin
            log_data[n_log] = bus.out_flit[15:0];
            log_last[n_log] = bus.out_flit[LB];
            log_port[n_log] = g;
            log_cyc[n_log]  = cyc;
            n_log++;
        end
        if (grant != '0 && grant != prev_grant && n_gnt < 256) begin
            gnt_seq[n_gnt] = g;
            n_gnt++;
        end
        prev_grant = grant;
        for (int p = 0; p < NP; p++) pop[p] = bus.in_flit[p][VB] && bus.in_ready[p];
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) if (pop[p]) head[p]++;
        bus.out_ready = rdy_toggle ? ~bus.out_ready : 1'b1;
        drive();
        cyc++;
    endtask

    task automatic run_until(string tag, int target, int budget);
        int k;
        k = 0;
        while (n_log < target && k < budget) begin
            step();
            k++;
        end
        chk({tag, " done"}, n_log, target);
    endtask

    // Compares logged output against the expected port order and each port's pushed flits
    task automatic chk_order(string tag);
        int m;
        int p;
        m = 0;
        chk({tag, " count"}, n_log - log_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && log_base + i < n_log; i++) begin
            p = exp_q[i];
            if (log_port[log_base + i] != p) m++;
            else begin
                if ({log_last[log_base + i], log_data[log_base + i]} != mem[p][exp_rd[p]]) m++;
                exp_rd[p]++;
            end
        end
        chk({tag, " order"}, m, 0);
        exp_q.delete();
    endtask

    task automatic begin_test();
        log_base = n_log;
        gnt_base = n_gnt;
    endtask

    initial begin
        int maxw;
        int w;
        int last_pos [NP];
        int gcnt [NP];

        n_chk = 0; n_pass = 0; n_log = 0; n_gnt = 0; cyc = 0; viol = 0; ser = 0;
        rdy_toggle = 1'b0;
        prev_grant = '0;
        for (int p = 0; p < NP; p++) begin
            head[p] = 0; tail[p] = 0; exp_rd[p] = 0;
        end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_flit = '0;

        // Reset with requesters already valid: nothing may be granted
        begin_test();
        push_pkt(0, 4, 14'h0000);
        push_pkt(2, 4, 14'h0000);
        step();
        step();
        @(negedge clk);
        chk("reset grant", int'(grant), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset out valid", int'(bus.out_flit[VB]), 0);
        chk("reset in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = cyc;

        // Ports 0 and 2 together: port0 first, one bubble, then port2
        expect_port(0, 4);
        expect_port(2, 4);
        run_until("t1", log_base + 8, 40);
        chk("t1 first latency", log_cyc[log_base] - c0, 1);
        chk("t1 bubble gap", log_cyc[log_base + 4] - log_cyc[log_base + 3], 2);
        chk_order("t1");
        step();

        // rr_ptr now 3: port3 beats port0
        begin_test();
        push_pkt(0, 4, 14'h0000);
        push_pkt(3, 4, 14'h0000);
        expect_port(3, 4);
        expect_port(0, 4);
        run_until("t1b", log_base + 8, 40);
        chk_order("t1b");
        step();

        // Port1 event chain of three packets stays contiguous while port0 waits
        begin_test();
        push_pkt(1, 4, 14'h0400);
        push_pkt(1, 4, 14'h0400);
        push_pkt(1, 4, 14'h0000);
        push_pkt(0, 4, 14'h0000);
        expect_port(1, 12);
        expect_port(0, 4);
        run_until("t2", log_base + 16, 60);
        chk("t2 chain contiguous", log_cyc[log_base + 11] - log_cyc[log_base], 11);
        chk("t2 grant count", n_gnt - gnt_base, 2);
        chk_order("t2");
        step();

        // out_ready toggling every cycle during a long payload
        begin_test();
        rdy_toggle = 1'b1;
        push_pkt(1, 8, 14'h0000);
        expect_port(1, 8);
        run_until("t3", log_base + 8, 60);
        chk("t3 span", log_cyc[log_base + 7] - log_cyc[log_base], 14);
        chk_order("t3");
        rdy_toggle = 1'b0;
        step();
        step();

        // Short packet closes a pending chain; rr_ptr advances to 0
        begin_test();
        push_pkt(3, 4, 14'h0400);
        push_pkt(3, 2, 14'h0000);
        push_pkt(3, 4, 14'h0000);
        push_pkt(0, 4, 14'h0000);
        expect_port(3, 6);
        expect_port(0, 4);
        expect_port(3, 4);
        run_until("t4", log_base + 14, 60);
        chk("t4 bubble after short", log_cyc[log_base + 6] - log_cyc[log_base + 5], 2);
        chk_order("t4");
        step();
        chk("t4 busy after", int'(busy), 0);

        // Reset while port2 presents its FLAGS flit
        begin_test();
        push_pkt(2, 4, 14'h0400);
        run_until("t5 pre", log_base + 2, 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_pkt(0, 4, 14'h0000);
        @(negedge clk);
        chk("t5 grant", int'(grant), 0);
        chk("t5 busy", int'(busy), 0);
        chk("t5 out valid", int'(bus.out_flit[VB]), 0);
        chk("t5 in_ready", int'(bus.in_ready), 0);
        expect_port(2, 3);
        expect_port(0, 4);
        expect_port(2, 1);
        run_until("t5", log_base + 8, 40);
        chk_order("t5");
        step();

        // All four ports saturated, 100 packets; rr_ptr starts at 3
        begin_test();
        for (int k = 0; k < 25; k++) begin
            for (int p = 0; p < NP; p++) push_pkt(p, 4, 14'h0000);
        end
        for (int k = 0; k < 100; k++) expect_port((3 + k) % NP, 4);
        run_until("t6", log_base + 400, 700);
        chk_order("t6");
        maxw = 0;
        for (int p = 0; p < NP; p++) begin
            last_pos[p] = -1;
            gcnt[p] = 0;
        end
        for (int i = gnt_base; i < n_gnt; i++) begin
            gcnt[gnt_seq[i]]++;
            w = (last_pos[gnt_seq[i]] < 0) ? i - gnt_base : i - last_pos[gnt_seq[i]] - 1;
            if (w > maxw) maxw = w;
            last_pos[gnt_seq[i]] = i;
        end
        chk("t6 grants p0", gcnt[0], 25);
        chk("t6 grants p1", gcnt[1], 25);
        chk("t6 grants p2", gcnt[2], 25);
        chk("t6 grants p3", gcnt[3], 25);
        chk("t6 max wait", maxw, 3);
        step();

        chk("invariants", viol, 0);
        w = 0;
        for (int p = 0; p < NP; p++) w += tail[p] - head[p];
        chk("sources drained", w, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
